// File: rtl/rr_mem_arbiter_if.sv
// Bus bundle between the round-robin arbiter, its requesting masters and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding system.
interface rr_mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        rw_in;
    logic [NUM_REQ*ADDR_W-1:0] addr_in;
    logic [NUM_REQ*DATA_W-1:0] wdata_in;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         rdata_out;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W-1:0]         mem_data_out;
    logic                      mem_rw;
    logic [OWN_W-1:0]          owner;
    logic                      busy;
    logic                      preempt;

    modport slave (
        input  req, lock, rw_in, addr_in, wdata_in, mem_data_out,
        output grant, rdata_out, mem_address, mem_data_in, mem_rw, owner, busy, preempt
    );

    modport master (
        output req, lock, rw_in, addr_in, wdata_in, mem_data_out,
        input  grant, rdata_out, mem_address, mem_data_in, mem_rw, owner, busy, preempt
    );
endinterface

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ masters, with locked tenures,
// MAX_HOLD preemption and a single dead (HANDOFF) cycle between owners.
module rr_mem_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    rr_mem_arbiter_if.slave   bus
);
    localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [OWN_W-1:0]   LAST_IDX   = OWN_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HANDOFF = 2'd2
    } state_t;

    state_t               state_reg,   state_next;
    logic [OWN_W-1:0]     owner_reg,   owner_next;
    logic [NUM_REQ-1:0]   grant_reg,   grant_next;
    logic [HOLD_W-1:0]    hold_reg,    hold_next;
    logic                 preempt_reg, preempt_next;

    logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    wdata_arr [NUM_REQ];

    logic                 pick_valid;
    logic [OWN_W-1:0]     pick_idx;
    int                   cand;
    logic                 others_req;
    logic                 preempt_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.addr_in[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.wdata_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // First asserted request scanning from owner+1 with wrap; the previous owner is checked last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = owner_reg;
        cand       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(owner_reg) + i) % NUM_REQ;
            if (!pick_valid && bus.req[OWN_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = OWN_W'(cand);
            end
        end
    end

    assign others_req = |(bus.req & ~grant_reg);
    assign preempt_ok = (MAX_HOLD != 0) && (hold_reg == HOLD_LIMIT) &&
                        !bus.lock[owner_reg] && others_req;

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        grant_next   = grant_reg;
        hold_next    = hold_reg;
        preempt_next = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_HANDOFF: begin
                if (pick_valid) begin
                    state_next = ST_GRANT;
                    owner_next = pick_idx;
                    grant_next = ONE_HOT0 << pick_idx;
                    hold_next  = '0;
                end else begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            ST_GRANT: begin
                // Counter saturates so a long locked tenure is revoked on the first edge after unlock.
                if (hold_reg != HOLD_LIMIT) begin
                    hold_next = hold_reg + 1'b1;
                end
                if (!bus.req[owner_reg]) begin
                    grant_next = '0;
                    state_next = ST_HANDOFF;
                end else if (preempt_ok) begin
                    grant_next   = '0;
                    preempt_next = 1'b1;
                    state_next   = ST_HANDOFF;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= LAST_IDX;
            grant_reg   <= '0;
            hold_reg    <= '0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            grant_reg   <= grant_next;
            hold_reg    <= hold_next;
            preempt_reg <= preempt_next;
        end
    end

    // Address/data follow the last owner even when idle; only rw is gated so nothing is written.
    assign bus.mem_address = addr_arr[owner_reg];
    assign bus.mem_data_in = wdata_arr[owner_reg];
    assign bus.mem_rw      = (state_reg == ST_GRANT) && bus.rw_in[owner_reg];
    assign bus.rdata_out   = bus.mem_data_out;
    assign bus.grant       = grant_reg;
    assign bus.owner       = owner_reg;
    assign bus.busy        = |grant_reg;
    assign bus.preempt     = preempt_reg;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_reg));
    a_write_needs_grant: assert property (@(posedge clk) disable iff (!reset) bus.mem_rw |-> (|grant_reg));

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed self-checking bench for rr_mem_arbiter with a small behavioural memory on the shared port.
module tb_rr_mem_arbiter;
    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rr_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rr_mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    assign bus.mem_data_out = mem[bus.mem_address];
    always @(posedge clk) begin
        if (bus.mem_rw) mem[bus.mem_address] <= bus.mem_data_in;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset        = 1'b0;
        bus.req      = '0;
        bus.lock     = '0;
        bus.rw_in    = '0;
        bus.addr_in  = '0;
        bus.wdata_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.req = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got %b want 00", bus.grant); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_vec++; if (bus.preempt !== 1'b0) begin n_err++; $display("FAIL reset_preempt got %b want 0", bus.preempt); end
        n_vec++; if (bus.owner !== 1'b1) begin n_err++; $display("FAIL reset_owner got %0d want 1", bus.owner); end
        n_vec++; if (bus.mem_rw !== 1'b0) begin n_err++; $display("FAIL reset_mem_rw got %b want 0", bus.mem_rw); end
        $display("test_reset: outputs held idle while reset low");
    endtask

    task automatic test_single;
        do_reset();
        bus.req = 2'b01;
        n_vec++; if (bus.grant !== 2'b00) begin n_err++; $display("FAIL single_pre_edge got %b want 00", bus.grant); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin
                n_err++; $display("FAIL single_grant cyc %0d got grant=%b busy=%b want 01/1", c, bus.grant, bus.busy);
            end
            n_vec++; if (bus.mem_rw !== 1'b0) begin n_err++; $display("FAIL single_mem_rw cyc %0d got %b want 0", c, bus.mem_rw); end
        end
        bus.req = 2'b00;
        tick();
        n_vec++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL single_handoff got grant=%b busy=%b want 00/0", bus.grant, bus.busy);
        end
        tick();
        n_vec++; if (bus.grant !== 2'b00 || bus.owner !== 1'b0) begin
            n_err++; $display("FAIL single_idle got grant=%b owner=%0d want 00/0", bus.grant, bus.owner);
        end
        $display("test_single: master 0 tenure of 5 cycles then idle");
    endtask

    task automatic test_two_masters;
        do_reset();
        bus.req = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (bus.grant !== 2'b01) begin n_err++; $display("FAIL two_m0 cyc %0d got %b want 01", c, bus.grant); end
        end
        bus.req = 2'b10;
        tick();
        n_vec++; if (bus.grant !== 2'b00 || bus.preempt !== 1'b0) begin
            n_err++; $display("FAIL two_dead1 got grant=%b preempt=%b want 00/0", bus.grant, bus.preempt);
        end
        tick();
        n_vec++; if (bus.grant !== 2'b10 || bus.owner !== 1'b1) begin
            n_err++; $display("FAIL two_m1 got grant=%b owner=%0d want 10/1", bus.grant, bus.owner);
        end
        tick();
        n_vec++; if (bus.grant !== 2'b10) begin n_err++; $display("FAIL two_m1_hold got %b want 10", bus.grant); end
        bus.req = 2'b01;
        tick();
        n_vec++; if (bus.grant !== 2'b00) begin n_err++; $display("FAIL two_dead2 got %b want 00", bus.grant); end
        tick();
        n_vec++; if (bus.grant !== 2'b01) begin n_err++; $display("FAIL two_m0_again got %b want 01", bus.grant); end
        $display("test_two_masters: 01 -> dead -> 10 -> dead -> 01");
    endtask

    task automatic test_write_read;
        do_reset();
        bus.addr_in  = {9'h1F8, 9'h1F8};
        bus.wdata_in = {8'h00, 8'h04};
        bus.rw_in    = 2'b01;
        bus.req      = 2'b01;
        n_vec++; if (bus.mem_rw !== 1'b0) begin n_err++; $display("FAIL wr_idle_rw got %b want 0", bus.mem_rw); end
        tick();
        n_vec++; if (bus.mem_address !== 9'h1F8 || bus.mem_data_in !== 8'h04 || bus.mem_rw !== 1'b1) begin
            n_err++; $display("FAIL wr_port got addr=%h data=%h rw=%b want 1f8/04/1", bus.mem_address, bus.mem_data_in, bus.mem_rw);
        end
        tick();
        bus.req = 2'b10;
        tick();
        n_vec++; if (bus.mem_rw !== 1'b0 || bus.grant !== 2'b00) begin
            n_err++; $display("FAIL wr_handoff got rw=%b grant=%b want 0/00", bus.mem_rw, bus.grant);
        end
        tick();
        n_vec++; if (bus.grant !== 2'b10 || bus.mem_rw !== 1'b0) begin
            n_err++; $display("FAIL rd_grant got grant=%b rw=%b want 10/0", bus.grant, bus.mem_rw);
        end
        n_vec++; if (bus.rdata_out !== 8'h04) begin n_err++; $display("FAIL rd_data got %h want 04", bus.rdata_out); end
        $display("test_write_read: m0 writes 04 to 1f8, m1 reads it back");
    endtask

    task automatic test_preempt;
        do_reset();
        bus.req = 2'b11;
        for (int c = 0; c < MAX_HOLD + 1; c++) begin
            tick();
            n_vec++; if (bus.grant !== 2'b01 || bus.preempt !== 1'b0) begin
                n_err++; $display("FAIL pre_m0 cyc %0d got grant=%b preempt=%b want 01/0", c, bus.grant, bus.preempt);
            end
        end
        tick();
        n_vec++; if (bus.grant !== 2'b00 || bus.preempt !== 1'b1) begin
            n_err++; $display("FAIL pre_cut0 got grant=%b preempt=%b want 00/1", bus.grant, bus.preempt);
        end
        for (int c = 0; c < MAX_HOLD + 1; c++) begin
            tick();
            n_vec++; if (bus.grant !== 2'b10 || bus.preempt !== 1'b0) begin
                n_err++; $display("FAIL pre_m1 cyc %0d got grant=%b preempt=%b want 10/0", c, bus.grant, bus.preempt);
            end
        end
        tick();
        n_vec++; if (bus.grant !== 2'b00 || bus.preempt !== 1'b1) begin
            n_err++; $display("FAIL pre_cut1 got grant=%b preempt=%b want 00/1", bus.grant, bus.preempt);
        end
        tick();
        n_vec++; if (bus.grant !== 2'b01 || bus.preempt !== 1'b0) begin
            n_err++; $display("FAIL pre_back_m0 got grant=%b preempt=%b want 01/0", bus.grant, bus.preempt);
        end
        $display("test_preempt: grants alternate 01,00,10,00,01 under MAX_HOLD");
    endtask

    task automatic test_lock;
        do_reset();
        bus.lock = 2'b01;
        bus.req  = 2'b11;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_vec++; if (bus.grant !== 2'b01 || bus.preempt !== 1'b0) begin
                n_err++; $display("FAIL lock_hold cyc %0d got grant=%b preempt=%b want 01/0", c, bus.grant, bus.preempt);
            end
        end
        bus.lock = 2'b00;
        tick();
        n_vec++; if (bus.grant !== 2'b00 || bus.preempt !== 1'b1) begin
            n_err++; $display("FAIL lock_release got grant=%b preempt=%b want 00/1", bus.grant, bus.preempt);
        end
        tick();
        n_vec++; if (bus.grant !== 2'b10 || bus.owner !== 1'b1) begin
            n_err++; $display("FAIL lock_next got grant=%b owner=%0d want 10/1", bus.grant, bus.owner);
        end
        $display("test_lock: no preempt for 40 locked cycles, preempt right after unlock");
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.addr_in  = {9'h010, 9'h020};
        bus.wdata_in = {8'h00, 8'h5A};
        bus.rw_in    = 2'b01;
        bus.req      = 2'b01;
        tick();
        n_vec++; if (bus.mem_rw !== 1'b1) begin n_err++; $display("FAIL ar_write got rw=%b want 1", bus.mem_rw); end
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if (bus.grant !== 2'b00 || bus.mem_rw !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL ar_immediate got grant=%b rw=%b busy=%b want 00/0/0", bus.grant, bus.mem_rw, bus.busy);
        end
        bus.req = 2'b10;
        tick();
        n_vec++; if (bus.grant !== 2'b00) begin n_err++; $display("FAIL ar_held got %b want 00", bus.grant); end
        reset = 1'b1;
        tick();
        n_vec++; if (bus.grant !== 2'b10 || bus.owner !== 1'b1) begin
            n_err++; $display("FAIL ar_after got grant=%b owner=%0d want 10/1", bus.grant, bus.owner);
        end
        $display("test_async_reset: grant and write killed before next edge");
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
        reset        = 1'b0;
        bus.req      = '0;
        bus.lock     = '0;
        bus.rw_in    = '0;
        bus.addr_in  = '0;
        bus.wdata_in = '0;
        test_reset();
        test_single();
        test_two_masters();
        test_write_read();
        test_preempt();
        test_lock();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
